// File: rtl/n1_pfetch.sv
// Instruction prefetch unit: issues single-word Wishbone reads for the address
// generation unit and buffers returned words in a small FIFO for the IR stage.
module n1_pfetch #(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [3:0] RTY_LIMIT  = 4'd15
) (
    input  logic        clk_i,
    input  logic        sync_rst_i,
    input  logic        pagu2pf_req_i,
    input  logic [15:0] pagu2pf_adr_i,
    output logic        pf2pagu_acc_o,
    input  logic        fc2pf_flush_i,
    output logic        pbus_cyc_o,
    output logic        pbus_stb_o,
    output logic        pbus_we_o,
    output logic [15:0] pbus_adr_o,
    input  logic        pbus_ack_i,
    input  logic        pbus_err_i,
    input  logic        pbus_rty_i,
    input  logic        pbus_stall_i,
    input  logic [15:0] pbus_dat_i,
    output logic        pf2ir_vld_o,
    output logic [15:0] pf2ir_dat_o,
    input  logic        ir2pf_rdy_i,
    output logic        pf2fc_err_o,
    output logic        pf2fc_bsy_o,
    output logic [1:0]  prb_pf_state_o,
    output logic [3:0]  prb_pf_cnt_o
);

    localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] DEPTH_L = 4'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        WAIT  = 2'b10,
        DRAIN = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   adr_q;
    logic [3:0]    rty_q;
    logic          err_q;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   cnt_q;

    logic       acc, push, pop, set_err, rty_inc, resp, pend;
    logic [3:0] fill_lvl;

    // The outstanding fetch reserves a slot so an ack can always be stored.
    assign pend     = (state_q != IDLE);
    assign fill_lvl = 4'(cnt_q) + {3'b000, pend};
    assign resp     = pbus_ack_i | pbus_err_i | pbus_rty_i;
    assign pop      = pf2ir_vld_o & ir2pf_rdy_i;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        acc     = 1'b0;
        push    = 1'b0;
        set_err = 1'b0;
        rty_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (pagu2pf_req_i && !fc2pf_flush_i && !err_q && !sync_rst_i &&
                    (fill_lvl < DEPTH_L)) begin
                    acc     = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (fc2pf_flush_i)      state_d = IDLE;
                else if (!pbus_stall_i) state_d = WAIT;
            end
            WAIT: begin
                if (fc2pf_flush_i) begin
                    // A response in the flush cycle already closes the transaction.
                    state_d = resp ? IDLE : DRAIN;
                end else if (pbus_err_i) begin
                    set_err = 1'b1;
                    state_d = IDLE;
                end else if (pbus_ack_i) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (pbus_rty_i) begin
                    if (rty_q == RTY_LIMIT) begin
                        set_err = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rty_inc = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            DRAIN: begin
                if (resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q  <= IDLE;
            adr_q    <= 16'h0000;
            rty_q    <= 4'd0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (acc) adr_q <= pagu2pf_adr_i;

            if (acc)          rty_q <= 4'd0;
            else if (rty_inc) rty_q <= rty_q + 4'd1;

            if (fc2pf_flush_i) err_q <= 1'b0;
            else if (set_err)  err_q <= 1'b1;

            if (fc2pf_flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + CNT_ONE;
                    2'b01:   cnt_q <= cnt_q - CNT_ONE;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    // NOTE: the data array is deliberately not reset; the count and pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= pbus_dat_i;
    end

    assign pf2pagu_acc_o  = acc;
    assign pbus_cyc_o     = pend;
    assign pbus_stb_o     = (state_q == REQ);
    assign pbus_we_o      = 1'b0;
    assign pbus_adr_o     = pend ? adr_q : 16'h0000;
    assign pf2ir_vld_o    = (cnt_q != '0);
    assign pf2ir_dat_o    = pf2ir_vld_o ? mem_q[rd_ptr_q] : 16'h0000;
    assign pf2fc_err_o    = err_q;
    assign pf2fc_bsy_o    = pend;
    assign prb_pf_state_o = state_q;
    assign prb_pf_cnt_o   = fill_lvl;

endmodule

// File: doc/n1_pfetch.md
N1_PFETCH -- requirements
Module: N1_pfetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning instruction buffer entries (power of two, range 2..8).
REQ-002 SHALL have parameter RTY_LIMIT, default 4'd15, meaning the maximum consecutive retries before the fetch is flagged as an error.
REQ-003 SHALL have ports:
clk_i  in  1  module clock; all logic is synchronous to its rising edge.
sync_rst_i  in  1  reset, synchronous and active-high.
pagu2pf_req_i  in  1  fetch request from the address generation unit.
pagu2pf_adr_i  in  16  fetch address, valid with pagu2pf_req_i.
pf2pagu_acc_o  out  1  request accepted this cycle.
fc2pf_flush_i  in  1  change of flow: discard buffered and in-flight data.
pbus_cyc_o  out  1  wishbone cycle.
pbus_stb_o  out  1  wishbone strobe.
pbus_we_o  out  1  write enable, tied to 0.
pbus_adr_o  out  16  wishbone address.
pbus_ack_i  in  1  acknowledge.
pbus_err_i  in  1  error.
pbus_rty_i  in  1  retry.
pbus_stall_i  in  1  pipeline stall.
pbus_dat_i  in  16  read data.
pf2ir_vld_o  out  1  buffer head valid.
pf2ir_dat_o  out  16  buffer head instruction word.
ir2pf_rdy_i  in  1  IR consumes the head word when high together with pf2ir_vld_o.
pf2fc_err_o  out  1  sticky bus error flag.
pf2fc_bsy_o  out  1  bus transaction in flight.
prb_pf_state_o  out  2  probe: FSM state.
prb_pf_cnt_o  out  4  probe: buffer fill level.

Function
REQ-004 SHALL implement FSM states IDLE=2'b00, REQ=2'b01, WAIT=2'b10, DRAIN=2'b11.
REQ-005 SHALL assert pf2pagu_acc_o in IDLE when pagu2pf_req_i=1, fc2pf_flush_i=0, pf2fc_err_o=0 and fill level < FIFO_DEPTH; on acceptance it SHALL latch the address and go to REQ.
REQ-006 SHALL drive pbus_cyc_o=1 in REQ, WAIT and DRAIN, and pbus_stb_o=1 only in REQ; pbus_adr_o SHALL equal the latched address whenever pbus_cyc_o=1.
REQ-007 In REQ, when pbus_stall_i=0, SHALL go to WAIT next cycle; while pbus_stall_i=1, SHALL hold all bus outputs stable.
REQ-008 In WAIT, on pbus_ack_i SHALL push pbus_dat_i into the buffer and go to IDLE; pbus_cyc_o SHALL drop the following cycle.
REQ-009 In WAIT, on pbus_rty_i SHALL increment the retry counter and return to REQ with the same address; when the counter reaches RTY_LIMIT, a further retry SHALL be treated as an error.
REQ-010 In WAIT, on pbus_err_i SHALL set pf2fc_err_o, push nothing and go to IDLE. Priority when several are high is err > ack > rty.
REQ-011 fc2pf_flush_i in REQ SHALL deassert stb and cyc next cycle and go to IDLE; in WAIT it SHALL go to DRAIN.
REQ-012 DRAIN SHALL wait for ack, err or rty, discard the response without setting the error flag, then go to IDLE.
REQ-013 fc2pf_flush_i SHALL empty the buffer in the same cycle; a simultaneous ack SHALL be discarded.
REQ-014 The fill level SHALL count buffered words plus one for an outstanding fetch, so the buffer can never overflow.
REQ-015 The buffer SHALL be a FIFO of FIFO_DEPTH entries with wrap-around pointers.
REQ-016 A push and a pop in the same cycle SHALL leave the fill level unchanged; when the buffer is empty, pf2ir_dat_o SHALL present the pushed word on the cycle after the push.
REQ-017 pf2fc_bsy_o SHALL equal pbus_cyc_o.
REQ-018 The retry counter SHALL clear on acceptance of a new request.

Reset
REQ-019 sync_rst_i=1 SHALL force the state to IDLE, empty the buffer, clear the retry counter and clear pf2fc_err_o.
REQ-020 During reset, all outputs SHALL be 0, including pbus_adr_o=16'h0000 and pf2ir_dat_o=16'h0000.
REQ-021 Reset asserted mid-transaction SHALL drop pbus_cyc_o the next cycle; responses arriving afterwards SHALL be ignored.
REQ-022 pf2fc_err_o, once set, SHALL clear only by reset or flush.

Verification
REQ-023 Request adr 16'h1234, no stall, ack with 16'hBEEF after 1 cycle -> stb high for 1 cycle; pf2ir_vld_o=1 with dat 16'hBEEF.
REQ-024 pbus_stall_i held 3 cycles in REQ -> stb and adr stable for 4 cycles; exactly one word is buffered.
REQ-025 Two rty responses then ack -> address re-issued twice; one word is buffered; pf2fc_err_o=0.
REQ-026 16 consecutive rty responses -> pf2fc_err_o=1; pf2pagu_acc_o stays 0 afterwards.
REQ-027 Flush in WAIT, then ack 16'hAAAA -> DRAIN for 1 cycle; buffer empty; no vld.
REQ-028 ir2pf_rdy_i=0 with 2 words buffered -> acc=0 (full); one pop -> acc=1 the next cycle.
